axi4l_regbank_slave: RTL and testbench

- AXI4-Lite responder holding the configuration register bank that the bus master programs: weights, biases, input grid and core control.
- Accepts single-beat writes and reads on a 32-bit address / 8-bit data bus.
- Presents every register as a flat parallel output to the datapath, with one read-only status slot fed from the core.
- Sits between the top-level AXI4-Lite port and the network core.

---
 rtl/axi4l_regbank_slave.sv | 155 +++++++++++++++
 tb/tb_axi4l_regbank_slave.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_regbank_slave.sv
// AXI4-Lite register bank: flat register outputs, one read-only status slot, optional REGBANK_WSTRB_EN byte-lane strobes.
// Write commits 1 cycle after AW and W are both held; read data is registered at the AR handshake.
module axi4l_regbank_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    NUM_REGS   = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    RO_INDEX   = 63
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   input  logic [DATA_WIDTH-1:0]          status_in,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
   output logic                           wr_pulse,
   output logic [$clog2(NUM_REGS)-1:0]    wr_index
);
   localparam int                    IW    = $clog2(NUM_REGS);
   localparam int                    NB    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] NUM_A = ADDR_WIDTH'(NUM_REGS);
   localparam logic [IW-1:0]         RO_I  = IW'(RO_INDEX);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  ready_en, aw_held, w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_off, ar_off;
   logic [DATA_WIDTH-1:0] w_data_q, new_word;
   logic [IW-1:0]         aw_idx, ar_idx;
   logic                  aw_err, ar_err, wr_err, wr_any, commit, do_update;
   logic                  aw_hs, w_hs, ar_hs;

   // ready_en keeps the ready lines low for the first cycle after reset release
   assign awready = ready_en && !aw_held;
   assign wready  = ready_en && !w_held;
   assign arready = ready_en && !rvalid;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign ar_hs   = arvalid && arready;

   always_comb begin
      aw_off    = aw_addr_q - BASE_ADDR;
      ar_off    = araddr - BASE_ADDR;
      aw_idx    = aw_off[IW+1:2];
      ar_idx    = ar_off[IW+1:2];
      aw_err    = (aw_addr_q[1:0] != 2'b00) || (aw_addr_q < BASE_ADDR) || ((aw_off >> 2) >= NUM_A);
      ar_err    = (araddr[1:0] != 2'b00) || (araddr < BASE_ADDR) || ((ar_off >> 2) >= NUM_A);
      wr_err    = aw_err || (aw_idx == RO_I);
      commit    = aw_held && w_held && !bvalid;
      do_update = commit && !wr_err && wr_any;
   end

`ifdef REGBANK_WSTRB_EN
   logic [NB-1:0] w_strb_q;

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)      w_strb_q <= '0;
      else if (w_hs) w_strb_q <= wstrb;
   end

   always_comb begin
      new_word = regs[aw_idx];
      for (int b = 0; b < NB; b++)
         if (w_strb_q[b]) new_word[b*8 +: 8] = w_data_q[b*8 +: 8];
      wr_any = |w_strb_q;
   end
`else
   logic unused_wstrb;
   assign unused_wstrb = ^wstrb;
   assign new_word     = w_data_q;
   assign wr_any       = 1'b1;
`endif

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         ready_en  <= 1'b0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         bvalid    <= 1'b0;
         bresp     <= 2'b00;
         rvalid    <= 1'b0;
         rresp     <= 2'b00;
         rdata     <= '0;
         wr_pulse  <= 1'b0;
         wr_index  <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         ready_en <= 1'b1;
         wr_pulse <= do_update;

         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= awaddr;
         end else if (commit) begin
            aw_held   <= 1'b0;
         end

         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= wdata;
         end else if (commit) begin
            w_held   <= 1'b0;
         end

         if (commit) begin
            bvalid <= 1'b1;
            bresp  <= wr_err ? 2'b10 : 2'b00;
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end

         if (do_update) begin
            regs[aw_idx] <= new_word;
            wr_index     <= aw_idx;
         end

         // regs[] is sampled before this edge's write lands, so a colliding read sees the old value
         if (ar_hs) begin
            rvalid <= 1'b1;
            if (ar_err) begin
               rdata <= '0;
               rresp <= 2'b10;
            end else if (ar_idx == RO_I) begin
               rdata <= status_in;
               rresp <= 2'b00;
            end else begin
               rdata <= regs[ar_idx];
               rresp <= 2'b00;
            end
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end
endmodule

// File: tb/tb_axi4l_regbank_slave.sv
// Directed, table-driven bench for axi4l_regbank_slave plus hand sequences for stalls, ordering and reset.
module tb_axi4l_regbank_slave;
   logic         clk = 1'b0;
   logic         rstn;
   logic [31:0]  awaddr, araddr;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready, wr_pulse;
   logic [7:0]   wdata, rdata, status_in;
   logic [0:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [511:0] regs_out;
   logic [5:0]   wr_index;

   always #5 clk = ~clk;

   axi4l_regbank_slave dut (
      .clk(clk), .rstn(rstn),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .status_in(status_in), .regs_out(regs_out),
      .wr_pulse(wr_pulse), .wr_index(wr_index)
   );

   typedef struct {
      logic        rd;
      logic [31:0] addr;
      logic [7:0]  data;
      logic [1:0]  resp;
      logic [7:0]  rdata;
   } vec_t;

   vec_t       vecs [14];
   logic [7:0] model [64];
   int         n_total = 0;
   int         n_pass  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic check_regs(input string name);
      int bad = 0;
      for (int i = 0; i < 64; i++)
         if (regs_out[i*8 +: 8] !== model[i]) bad++;
      check(name, bad, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [7:0] d, input logic s,
                            output logic [1:0] resp, output int lat, output logic pulse,
                            output logic [5:0] idx);
      logic aw_go, w_go, aw_done, w_done;
      int   n;
      awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
      awvalid = 1'b1; wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      resp = 2'b11; lat = 99; pulse = 1'b0; idx = '0;
      while (!(aw_done && w_done) && n < 20) begin
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         tick();
         n++;
         if (aw_go) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_go)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bvalid) begin
            lat = k; resp = bresp; pulse = wr_pulse; idx = wr_index;
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [7:0] d, output logic [1:0] resp,
                           output int lat);
      logic go;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      d = '0; resp = 2'b11; lat = 99;
      for (int n = 0; n < 20; n++) begin
         go = arready;
         tick();
         if (go) break;
      end
      arvalid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (rvalid) begin
            lat = k; d = rdata; resp = rresp;
            break;
         end
         tick();
      end
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [1:0] resp;
      logic [7:0] d;
      logic [5:0] idx;
      logic       pulse, aw_go, w_go;
      int         lat, stable, pulses, phase, cnt;

      vecs[0]  = '{1'b0, 32'h0000_0000, 8'h20, 2'b00, 8'h00};
      vecs[1]  = '{1'b0, 32'h0000_0014, 8'h33, 2'b00, 8'h00};
      vecs[2]  = '{1'b0, 32'h0000_0102, 8'hAA, 2'b10, 8'h00};
      vecs[3]  = '{1'b0, 32'h0000_00FC, 8'hBB, 2'b10, 8'h00};
      vecs[4]  = '{1'b0, 32'h0000_0100, 8'hCC, 2'b10, 8'h00};
      vecs[5]  = '{1'b0, 32'h0000_00F8, 8'h7F, 2'b00, 8'h00};
      vecs[6]  = '{1'b0, 32'h8000_0000, 8'h11, 2'b10, 8'h00};
      vecs[7]  = '{1'b1, 32'h0000_0000, 8'h00, 2'b00, 8'h20};
      vecs[8]  = '{1'b1, 32'h0000_0014, 8'h00, 2'b00, 8'h33};
      vecs[9]  = '{1'b1, 32'h0000_00FC, 8'h00, 2'b00, 8'h5A};
      vecs[10] = '{1'b1, 32'h0000_0200, 8'h00, 2'b10, 8'h00};
      vecs[11] = '{1'b1, 32'h0000_0101, 8'h00, 2'b10, 8'h00};
      vecs[12] = '{1'b1, 32'h0000_00F8, 8'h00, 2'b00, 8'h7F};
      vecs[13] = '{1'b1, 32'h0000_0008, 8'h00, 2'b00, 8'h00};
      for (int i = 0; i < 64; i++) model[i] = 8'h00;

      rstn = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 1'b1; wvalid = 1'b0;
      bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; status_in = 8'h5A;

      tick(); tick();
      check("rst_ready", {awready, wready, arready}, 3'b000);
      check("rst_valid", {bvalid, rvalid, wr_pulse}, 3'b000);
      check("rst_resp", {bresp, rresp, rdata, wr_index}, '0);
      check_regs("rst_regs");
      rstn = 1'b0;
      #1;
      check("ready_low_at_release", {awready, wready, arready}, 3'b000);
      tick();
      check("ready_after_release", {awready, wready, arready}, 3'b111);

      for (int i = 0; i < 14; i++) begin
         if (!vecs[i].rd) begin
            axi_write(vecs[i].addr, vecs[i].data, 1'b1, resp, lat, pulse, idx);
            check($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
            check($sformatf("v%0d_blat", i), lat, 1);
            check($sformatf("v%0d_pulse", i), pulse, vecs[i].resp == 2'b00);
            if (vecs[i].resp == 2'b00) begin
               check($sformatf("v%0d_index", i), idx, vecs[i].addr[7:2]);
               model[vecs[i].addr[7:2]] = vecs[i].data;
            end
            check_regs($sformatf("v%0d_regs", i));
         end else begin
            axi_read(vecs[i].addr, d, resp, lat);
            check($sformatf("v%0d_rdata", i), d, vecs[i].rdata);
            check($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
            check($sformatf("v%0d_rlat", i), lat, 0);
         end
      end

      // W arrives three cycles before AW
      wdata = 8'hE0; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      check("w_first_held", wready, 1'b0);
      tick(); tick(); tick();
      check("w_first_no_commit", bvalid, 1'b0);
      awaddr = 32'h10; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("w_first_b_not_yet", bvalid, 1'b0);
      tick();
      check("w_first_b", {bvalid, bresp, wr_pulse, wr_index}, {1'b1, 2'b00, 1'b1, 6'd4});
      model[4] = 8'hE0;
      check_regs("w_first_regs");
      tick();
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (bvalid || wr_pulse) cnt++;
         tick();
      end
      check("w_first_single_b", cnt, 0);

      // B stall with a second write captured behind it
      bready = 1'b0; awaddr = 32'h20; wdata = 8'h11; wstrb = 1'b1;
      awvalid = 1'b1; wvalid = 1'b1; phase = 0; stable = 0; pulses = 0;
      for (int c = 0; c < 8; c++) begin
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         tick();
         if (aw_go && w_go) begin
            if (phase == 0) begin
               awaddr = 32'h24; wdata = 8'h22; phase = 1;
            end else begin
               awvalid = 1'b0; wvalid = 1'b0; phase = 2;
            end
         end
         if (bvalid && bresp == 2'b00) stable++;
         if (wr_pulse) pulses++;
      end
      check("bstall_stable", stable, 7);
      check("bstall_pulses", pulses, 1);
      check("bstall_second_captured", phase, 2);
      check("bstall_aw_blocked", awready, 1'b0);
      model[8] = 8'h11;
      check_regs("bstall_regs");
      bready = 1'b1;
      pulse = 1'b0; idx = '0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (wr_pulse) begin
            pulse = 1'b1; idx = wr_index;
            break;
         end
      end
      check("bstall_second_commit", {pulse, idx}, {1'b1, 6'd9});
      model[9] = 8'h22;
      check_regs("bstall_second_regs");
      tick();
      check("bstall_done", bvalid, 1'b0);

      // R stall; status sampled at the AR handshake
      rready = 1'b0; araddr = 32'hFC; arvalid = 1'b1; status_in = 8'h5A;
      tick();
      arvalid = 1'b0; status_in = 8'h99;
      stable = 0;
      for (int k = 0; k < 5; k++) begin
         if (rvalid && rdata == 8'h5A && rresp == 2'b00 && !arready) stable++;
         tick();
      end
      check("rstall_stable", stable, 5);
      rready = 1'b1;
      tick();
      check("rstall_done", rvalid, 1'b0);
      status_in = 8'h5A;

      // read and write commit to register 0 in the same cycle
      awaddr = 32'h0; wdata = 8'h44; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; araddr = 32'h0; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      check("collide_read_old", {rvalid, rdata, wr_pulse}, {1'b1, 8'h20, 1'b1});
      model[0] = 8'h44;
      check_regs("collide_regs");
      tick();

      // reset while only AW is held
      awaddr = 32'h30; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("half_aw_held", awready, 1'b0);
      rstn = 1'b1;
      tick(); tick();
      rstn = 1'b0;
      tick();
      check("half_aw_dropped", awready, 1'b1);
      cnt = 0;
      wdata = 8'h77; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (bvalid || wr_pulse) cnt++;
         tick();
      end
      check("half_no_commit", cnt, 0);
      for (int i = 0; i < 64; i++) model[i] = 8'h00;
      check_regs("half_regs_cleared");
      // pair the stray W so the bank is idle again
      awaddr = 32'h04; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      check("stray_w_commit", {bvalid, wr_index}, {1'b1, 6'd1});
      model[1] = 8'h77;
      tick();

      axi_write(32'h40, 8'h66, 1'b0, resp, lat, pulse, idx);
      check("wstrb0_bresp", resp, 2'b00);
`ifdef REGBANK_WSTRB_EN
      check("wstrb0_pulse", pulse, 1'b0);
`else
      check("wstrb0_pulse", pulse, 1'b1);
      model[16] = 8'h66;
`endif
      check_regs("wstrb0_regs");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
